cpu_wb_ctrl: RTL and testbench
==============================

Name: cpu_wb_ctrl

Overview:
- Write-side controller for the CPU register file.
- Generates the free-running T1/T2/T3 beat.
- Buffers writeback requests from the execute stage in a small in-order queue, and drives the register-file write port (we/waddr/wdata) so that exactly one write is presented per T3 beat.
- Flags read-after-write hazards against writes still in the queue.

Parameters:
- DEPTH, 4, writeback queue entries; power of 2, minimum 2.
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- t1  output  1  beat T1 active (one-hot with t2/t3).
- t2  output  1  beat T2 active.
- t3  output  1  beat T3 active; register file commits on this beat.
- wb_valid  input  1  execute stage offers a writeback.
- wb_ready  output  1  queue can accept this cycle.
- wb_addr  input  AW  destination register.
- wb_data  input  DW  writeback value.
- rf_we  output  1  register-file write enable.
- rf_waddr  output  AW  register-file write address.
- rf_wdata  output  DW  register-file write data.
- q_raddr1  input  AW  decode read address 1, for hazard check.
- q_raddr2  input  AW  decode read address 2.
- hazard1  output  1  q_raddr1 has a pending queued write.
- hazard2  output  1  q_raddr2 has a pending queued write.
- fwd_hit1  output  1  forwarded value valid for q_raddr1 (feature only).
- fwd_data1  output  DW  forwarded value for q_raddr1.
- fwd_hit2  output  1  forwarded value valid for q_raddr2.
- fwd_data2  output  DW  forwarded value for q_raddr2.
- count  output  $clog2(DEPTH)+1  number of queued entries.

Behaviour:
- Beat FSM:
  - States T1 -> T2 -> T3 -> T1, one clock each, free-running.
  - t1/t2/t3 are registered and exactly one-hot.
  - Reset forces T1: t1=1, t2=0, t3=0 in the cycle after the reset edge.
- Queue:
  - Circular buffer with head/tail pointers (log2 DEPTH bits, natural wrap) and count in 0..DEPTH.
  - wb_ready = (count != DEPTH). It is combinational from count only and does not anticipate a same-cycle pop.
  - Accept when wb_valid & wb_ready.
  - wb_addr == 0 with an accept: the handshake completes but nothing is stored (r0 stays zero).
- Issue:
  - rf_we = t3 & (count != 0).
  - rf_waddr/rf_wdata = head entry whenever count != 0, else 0.
  - On a clock edge where rf_we=1, pop the head.
  - At most one register-file write per 3-cycle beat.
- Simultaneous push and pop: count unchanged, both pointers advance. When full, a pop does not make wb_ready high in the same cycle.
- Latency:
  - Push into an empty queue in a T1 or T2 cycle is written at the next T3 cycle.
  - Push during a T3 cycle into an empty queue is not visible that cycle; it is written at the following T3 (3 cycles later).
- Order: strictly FIFO; two queued writes to the same register commit oldest first.
- Hazards:
  - hazardN = (q_raddrN != 0) & any valid queue entry matching q_raddrN.
  - Combinational, evaluated on current queue contents. An entry being popped this cycle still counts.
  - The same-cycle incoming wb_addr is not included.
- Reset:
  - Flushes the queue: count=0, pointers 0. Pending writes are discarded.
  - rf_we=0 and hazard1/hazard2=0 after reset.
  - Reset asserted mid-beat overrides the beat FSM and any pop in that cycle.

Optional Feature:
- Macro: CPU_WB_BYPASS_EN.
- Defined:
  - fwd_hitN = hazardN.
  - fwd_dataN = data of the youngest valid entry matching q_raddrN (newest wins over older duplicates).
- Undefined: fwd_hit1/2 and fwd_data1/2 are tied to 0 and no compare-and-select logic is built. Hazard outputs are unaffected.

Test Plan:
- Reset then idle 6 cycles -> t1,t2,t3 repeat with period 3 starting with t1=1; rf_we=0; count=0; wb_ready=1.
- Push addr 5 / data 0xDEADBEEF during a T1 cycle -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF exactly at the next T3 cycle; count returns to 0 after it.
- Push 5 entries back-to-back with DEPTH=4 (addr 1..5, data 0x11..0x55) -> wb_ready drops after 4 accepts; writes drain one per T3 in order 1,2,3,4; the 5th is accepted only once count<4.
- Push addr 0 / data 0xFFFFFFFF -> handshake completes, count stays 0, no rf_we.
- Queue addr 7 = 0x1, then addr 7 = 0x2; set q_raddr1=7, q_raddr2=0 -> hazard1=1 and hazard2=0 until both writes are popped; with CPU_WB_BYPASS_EN, fwd_data1=0x2; commits occur as 0x1 then 0x2.
- Assert reset for 1 cycle with 3 entries queued mid-T2 -> next cycle count=0, t1=1, hazards 0; no rf_we occurs for the flushed entries.

Source files
------------

// File: rtl/cpu_wb_ctrl.sv
// cpu_wb_ctrl: T1/T2/T3 beat generator, in-order writeback queue and register-file write port.
// Optional CPU_WB_BYPASS_EN adds youngest-match forwarding of queued write data.
module cpu_wb_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     t1,
    output logic                     t2,
    output logic                     t3,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [AW-1:0]            wb_addr,
    input  logic [DW-1:0]            wb_data,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_waddr,
    output logic [DW-1:0]            rf_wdata,
    input  logic [AW-1:0]            q_raddr1,
    input  logic [AW-1:0]            q_raddr2,
    output logic                     hazard1,
    output logic                     hazard2,
    output logic                     fwd_hit1,
    output logic [DW-1:0]            fwd_data1,
    output logic                     fwd_hit2,
    output logic [DW-1:0]            fwd_data2,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {T1, T2, T3} beat_t;
    beat_t beat, beat_nxt;
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head, tail;
    logic push, pop;
    logic [DEPTH-1:0] m1, m2;
    always_comb beat_nxt = beat == T1 ? T2 : beat == T2 ? T3 : T1;
    always_ff @(posedge clk) begin
        if (reset) begin
            beat <= T1;
            {t1, t2, t3} <= 3'b100;
        end else begin
            beat <= beat_nxt;
            t1 <= beat_nxt == T1;
            t2 <= beat_nxt == T2;
            t3 <= beat_nxt == T3;
        end
    end
    // writes to r0 complete the handshake but are never stored
    assign wb_ready = count != CW'(DEPTH);
    assign push     = wb_valid & wb_ready & (wb_addr != '0);
    assign rf_we    = t3 & (count != '0);
    assign pop      = rf_we;
    assign rf_waddr = count != '0 ? addr_q[head] : '0;
    assign rf_wdata = count != '0 ? data_q[head] : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                addr_q[tail] <= wb_addr;
                data_q[tail] <= wb_data;
                tail <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    // match vectors are ordered by age: bit 0 is the oldest entry
    always_comb begin
        m1 = '0;
        m2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            m1[k] = (CW'(k) < count) && (q_raddr1 != '0) && (addr_q[head + PW'(k)] == q_raddr1);
            m2[k] = (CW'(k) < count) && (q_raddr2 != '0) && (addr_q[head + PW'(k)] == q_raddr2);
        end
    end
    assign hazard1 = |m1;
    assign hazard2 = |m2;
`ifdef CPU_WB_BYPASS_EN
    always_comb begin
        fwd_data1 = '0;
        fwd_data2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (m1[k]) fwd_data1 = data_q[head + PW'(k)];
            if (m2[k]) fwd_data2 = data_q[head + PW'(k)];
        end
    end
    assign fwd_hit1 = hazard1;
    assign fwd_hit2 = hazard2;
`else
    assign fwd_hit1  = 1'b0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;
`endif
endmodule

// File: tb/tb_cpu_wb_ctrl.sv
// tb_cpu_wb_ctrl: scoreboard bench for cpu_wb_ctrl; a per-cycle monitor compares beat, queue and write port.
module tb_cpu_wb_ctrl;
    localparam int DEPTH = 4;
    logic clk = 0, reset = 1;
    logic t1, t2, t3, wb_valid = 0, wb_ready, rf_we;
    logic [4:0] wb_addr = 0, rf_waddr, q_raddr1 = 0, q_raddr2 = 0;
    logic [31:0] wb_data = 0, rf_wdata, fwd_data1, fwd_data2;
    logic hazard1, hazard2, fwd_hit1, fwd_hit2;
    logic [2:0] count;
    typedef struct {logic [4:0] a; logic [31:0] d;} wr_t;
    wr_t exp_q[$];
    int vectors = 0, miscompares = 0, ph = 0, stalls = 0;
    logic we_e, h1, h2;
    logic [31:0] f1, f2;

    cpu_wb_ctrl #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
        .clk(clk), .reset(reset), .t1(t1), .t2(t2), .t3(t3),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .q_raddr1(q_raddr1), .q_raddr2(q_raddr2), .hazard1(hazard1), .hazard2(hazard2),
        .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) ph = 0;
        else begin
            check("beat", {t1, t2, t3}, ph == 0 ? 3'b100 : ph == 1 ? 3'b010 : 3'b001);
            check("count", count, exp_q.size());
            check("wb_ready", wb_ready, exp_q.size() != DEPTH);
            we_e = ph == 2 && exp_q.size() != 0;
            check("rf_we", rf_we, we_e);
            check("rf_waddr", rf_waddr, exp_q.size() != 0 ? exp_q[0].a : 5'd0);
            check("rf_wdata", rf_wdata, exp_q.size() != 0 ? exp_q[0].d : 32'd0);
            h1 = 0; h2 = 0; f1 = 0; f2 = 0;
            foreach (exp_q[i]) begin
                if (q_raddr1 != 0 && exp_q[i].a == q_raddr1) begin h1 = 1; f1 = exp_q[i].d; end
                if (q_raddr2 != 0 && exp_q[i].a == q_raddr2) begin h2 = 1; f2 = exp_q[i].d; end
            end
            check("hazard1", hazard1, h1);
            check("hazard2", hazard2, h2);
`ifdef CPU_WB_BYPASS_EN
            check("fwd1", {fwd_hit1, fwd_data1}, {h1, f1});
            check("fwd2", {fwd_hit2, fwd_data2}, {h2, f2});
`else
            check("fwd1", {fwd_hit1, fwd_data1}, 33'd0);
            check("fwd2", {fwd_hit2, fwd_data2}, 33'd0);
`endif
            if (we_e) void'(exp_q.pop_front());
            ph = (ph + 1) % 3;
        end
    end

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        bit done = 0;
        wb_valid = 1; wb_addr = a; wb_data = d;
        for (int i = 0; i < 60 && !done; i++) begin
            if (wb_ready) done = 1; else stalls++;
            @(posedge clk); #1;
            if (done && a != 0) exp_q.push_back('{a, d});
        end
        if (!done) check("push_timeout", wb_ready, 1);
        wb_valid = 0;
    endtask

    task automatic wait_t(input int which);
        for (int i = 0; i < 6; i++) begin
            if ({t1, t2, t3} == (3'b100 >> which)) return;
            @(posedge clk); #1;
        end
        check("beat_timeout", {t1, t2, t3}, 3'b100 >> which);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 0;
        check("rst_t1", {t1, t2, t3}, 3'b100);
        check("rst_count", count, 0);
        idle(6);
        wait_t(0);
        push(5'd5, 32'hDEADBEEF);
        check("lat_t3", {t3, rf_we, rf_waddr}, {1'b0, 1'b0, 5'd5});
        @(posedge clk); #1;
        check("lat_we", {rf_we, rf_waddr, rf_wdata}, {1'b1, 5'd5, 32'hDEADBEEF});
        idle(2);
        check("lat_empty", count, 0);
        wait_t(2);
        push(5'd6, 32'h66);
        check("t3push_hidden", rf_we, 0);
        idle(6);
        for (int i = 1; i <= 5; i++) push(5'(i), 32'(i * 'h11));
        idle(15);
        stalls = 0;
        for (int i = 0; i < 8; i++) push(5'(8 + i), $urandom);
        check("full_seen", stalls > 0, 1);
        idle(27);
        push(5'd0, 32'hFFFFFFFF);
        check("r0_count", count, 0);
        idle(3);
        q_raddr1 = 7; q_raddr2 = 0;
        push(5'd7, 32'h1);
        push(5'd7, 32'h2);
        idle(9);
        q_raddr1 = 9; q_raddr2 = 10;
        wait_t(0);
        for (int i = 0; i < 4; i++) push(5'(9 + i), 32'hA0 + 32'(i));
        check("pre_rst_t2", {t2, count}, {1'b1, 3'd3});
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        exp_q.delete();
        check("rst2_count", count, 0);
        check("rst2_beat", {t1, t2, t3}, 3'b100);
        check("rst2_haz", {hazard1, hazard2}, 2'b00);
        idle(9);
        check("final_count", count, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
